// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver; ports clk, rst (sync, high), rx (async line) -> d_out (last good byte), valid/frame_err (1-cycle pulses), busy (not idle)
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] d_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, d_n;
  logic valid_n, ferr_n;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    d_n     = d_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: if (!s2) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = s2 ? IDLE : DATA;
      end else cnt_n = cnt + CW'(1);
      DATA: if (cnt == FULL) begin
        cnt_n   = '0;
        shift_n = {s2, shift[7:1]};
        idx_n   = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end else cnt_n = cnt + CW'(1);
      STOP: if (cnt == FULL) begin
        cnt_n   = '0;
        state_n = s2 ? IDLE : BRK;
        valid_n = s2;
        ferr_n  = !s2;
        d_n     = s2 ? shift : d_out;
      end else cnt_n = cnt + CW'(1);
      BRK: state_n = s2 ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      d_out     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      s1        <= rx;
      s2        <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      d_out     <= d_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      busy      <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: scoreboard bench for uart_rx_byte with directed and random 8N1 frames
module tb_uart_rx_byte;
  localparam int CPB = 16;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] d_out;
  logic valid, frame_err, busy;
  int total = 0, bad = 0, cyc = 0;
  logic [7:0] last_good = 8'h00;
  typedef struct {bit err; logic [7:0] d; int c;} ev_t;
  ev_t q[$];
  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .d_out(d_out),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", n, a, x, cyc);
    end
  endtask
  // Line bit i is driven from a negedge for CPB cycles. The stop-bit midpoint is
  // CPB/2 + 9*CPB after the start edge; 2 sync flops plus the IDLE decision add 3.
  task automatic send(input logic [7:0] b, input logic stop, input int rst_bit = -1);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (rst_bit < 0) begin
      q.push_back('{err: !stop, d: stop ? b : last_good, c: cyc + 3 + CPB / 2 + 9 * CPB});
      if (stop) last_good = b;
    end
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        return;
      end
      repeat (CPB) @(negedge clk);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (valid === 1'b1 && frame_err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL exclusive valid=1 frame_err=1 want one-hot cyc=%0d", cyc);
    end else if (valid === 1'b1 || frame_err === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse valid=%b frame_err=%b want none cyc=%0d", valid, frame_err, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", frame_err, e.err);
        chk("pulse_cycle", cyc, e.c);
        chk("pulse_dout", d_out, e.d);
        chk("pulse_busy", busy, e.err);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b;
    bit ok;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", d_out, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);
    repeat (100) @(negedge clk);
    chk("idle_busy", busy, 0);
    send(8'hA5, 1'b1);
    drain();
    chk("a5_dout", d_out, 8'hA5);
    chk("a5_busy", busy, 0);
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", busy, 1);
    repeat (30) @(negedge clk);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_dout", d_out, 8'hA5);
    send(8'h3C, 1'b0);
    repeat (30) @(negedge clk);
    drain();
    chk("break_busy", busy, 1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_exit_busy", busy, 0);
    chk("ferr_dout", d_out, 8'hA5);
    repeat (20) @(negedge clk);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drain();
    chk("b2b_dout", d_out, 8'hFF);
    repeat (20) @(negedge clk);
    // the transmitter abandons the frame as well, so the line returns idle
    send(8'h81, 1'b1, 4);
    last_good = 8'h00;
    chk("midrst_dout", d_out, 8'h00);
    chk("midrst_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("midrst_idle", busy, 0);
    send(8'h5A, 1'b1);
    drain();
    chk("after_rst_dout", d_out, 8'h5A);
    for (int k = 0; k < 24; k++) begin
      b  = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      send(b, ok);
      if (!ok) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
      end else repeat ($urandom_range(0, 1) * $urandom_range(0, 20)) @(negedge clk);
    end
    drain();
    chk("rand_dout", d_out, last_good);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
